strobe_interval_meter: RTL and testbench

//   Receive-side companion to the strobe counter: measures enable ticks between successive strobe pulses.

---
 rtl/strobe_interval_meter.sv | 130 +++++++++++++
 tb/tb_strobe_interval_meter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/strobe_interval_meter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : strobe_interval_meter                                            |
// | Purpose : Measures enable ticks between strobe pulses, reports them over   |
// |           valid/ready and tracks lock against an expected period.          |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module strobe_interval_meter #(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             strobe_in,
  input  logic [WIDTH-1:0] expected,
  output logic [WIDTH-1:0] meas_value,
  output logic             meas_overflow,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic             locked,
  output logic             mismatch,
  output logic [7:0]       drop_count
);

  localparam logic [WIDTH-1:0] c_cnt_max = '1;
  localparam logic [7:0]       c_lock    = 8'(LOCK_COUNT);
  localparam logic [7:0]       c_drop_max = 8'hFF;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_tick_cnt;
  logic             r_ovf_flag;
  logic [7:0]       r_match_cnt;
  logic [WIDTH-1:0] r_meas_value;
  logic             r_meas_overflow;
  logic             r_meas_valid;
  logic             r_locked;
  logic             r_mismatch;
  logic [7:0]       r_drop_count;

  logic             w_sat;
  logic [WIDTH-1:0] w_final_cnt;
  logic             w_final_ovf;
  logic             w_complete;
  logic             w_match;
  logic [7:0]       w_match_inc;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // The opening strobe only arms the meter; every later strobe closes an interval.
  always_comb begin
    w_state_nxt = r_state;
    w_complete  = 1'b0;
    case (r_state)
      ST_IDLE:    if (strobe_in) w_state_nxt = ST_MEASURE;
      ST_MEASURE: w_complete = strobe_in;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Count including this cycle's enable, so a strobe-cycle tick closes its interval.
  always_comb begin
    w_sat       = (r_tick_cnt == c_cnt_max);
    w_final_cnt = (enable && !w_sat) ? r_tick_cnt + 1'b1 : r_tick_cnt;
    w_final_ovf = r_ovf_flag | (enable & w_sat);
    w_match     = (w_final_cnt == expected) && !w_final_ovf && (expected != '0);
    w_match_inc = (r_match_cnt >= c_lock) ? c_lock : r_match_cnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick_cnt      <= '0;
      r_ovf_flag      <= 1'b0;
      r_match_cnt     <= '0;
      r_meas_value    <= '0;
      r_meas_overflow <= 1'b0;
      r_meas_valid    <= 1'b0;
      r_locked        <= 1'b0;
      r_mismatch      <= 1'b0;
      r_drop_count    <= '0;
    end else begin
      r_mismatch <= 1'b0;

      if (r_state == ST_MEASURE && !strobe_in) begin
        r_tick_cnt <= w_final_cnt;
        r_ovf_flag <= w_final_ovf;
      end else begin
        r_tick_cnt <= '0;
        r_ovf_flag <= 1'b0;
      end

      if (w_complete) begin
        r_meas_value    <= w_final_cnt;
        r_meas_overflow <= w_final_ovf;
        r_meas_valid    <= 1'b1;
        if (r_meas_valid && !meas_ready && r_drop_count != c_drop_max)
          r_drop_count <= r_drop_count + 8'd1;
        // Lock tracking sees every interval, accepted or dropped.
        if (w_match) begin
          r_match_cnt <= w_match_inc;
          r_locked    <= (w_match_inc == c_lock);
        end else begin
          r_match_cnt <= '0;
          r_locked    <= 1'b0;
          r_mismatch  <= 1'b1;
        end
      end else if (meas_ready) begin
        r_meas_valid <= 1'b0;
      end
    end
  end

  assign meas_value    = r_meas_value;
  assign meas_overflow = r_meas_overflow;
  assign meas_valid    = r_meas_valid;
  assign locked        = r_locked;
  assign mismatch      = r_mismatch;
  assign drop_count    = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_strobe_interval_meter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_strobe_interval_meter                                         |
// | Purpose : Directed self-checking bench for strobe_interval_meter.          |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_strobe_interval_meter;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic             strobe_in;
  logic [WIDTH-1:0] expected;
  logic [WIDTH-1:0] meas_value;
  logic             meas_overflow;
  logic             meas_valid;
  logic             meas_ready;
  logic             locked;
  logic             mismatch;
  logic [7:0]       drop_count;

  int n_assert = 0;
  int n_fail   = 0;

  strobe_interval_meter #(.WIDTH(WIDTH), .LOCK_COUNT(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .strobe_in     (strobe_in),
    .expected      (expected),
    .meas_value    (meas_value),
    .meas_overflow (meas_overflow),
    .meas_valid    (meas_valid),
    .meas_ready    (meas_ready),
    .locked        (locked),
    .mismatch      (mismatch),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle; outputs are sampled 1 time unit after the closing edge.
  task automatic cyc(input logic en, input logic stb);
    enable    = en;
    strobe_in = stb;
    @(posedge clk);
    #1;
  endtask

  // ticks >= 1: enable held high, strobe on the last cycle.
  task automatic interval(input int ticks);
    for (int i = 0; i < ticks - 1; i++) cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_value"},    32'(meas_value),    32'd0);
    check({tag, "_ovf"},      32'(meas_overflow), 32'd0);
    check({tag, "_valid"},    32'(meas_valid),    32'd0);
    check({tag, "_locked"},   32'(locked),        32'd0);
    check({tag, "_mismatch"}, 32'(mismatch),      32'd0);
    check({tag, "_drop"},     32'(drop_count),    32'd0);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; strobe_in = 1'b0; expected = 4'd5; meas_ready = 1'b1;
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    check_all_zero("reset");
    rst = 1'b0;

    // 1: opening strobe, then three 5-tick intervals lock
    cyc(1'b1, 1'b1);
    check("t1_open_valid", 32'(meas_valid), 32'd0);
    interval(5);
    check("t1_r1_value",  32'(meas_value), 32'd5);
    check("t1_r1_valid",  32'(meas_valid), 32'd1);
    check("t1_r1_locked", 32'(locked),     32'd0);
    interval(5);
    check("t1_r2_locked", 32'(locked),     32'd0);
    interval(5);
    check("t1_r3_value",  32'(meas_value), 32'd5);
    check("t1_r3_locked", 32'(locked),     32'd1);
    check("t1_r3_mism",   32'(mismatch),   32'd0);

    // 2: one 6-tick interval breaks lock, three 5s relock
    interval(6);
    check("t2_value",  32'(meas_value), 32'd6);
    check("t2_mism",   32'(mismatch),   32'd1);
    check("t2_locked", 32'(locked),     32'd0);
    cyc(1'b1, 1'b0);
    check("t2_mism_pulse", 32'(mismatch), 32'd0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    check("t2_rl1_locked", 32'(locked), 32'd0);
    interval(5);
    check("t2_rl2_locked", 32'(locked), 32'd0);
    interval(5);
    check("t2_rl3_locked", 32'(locked), 32'd1);

    // 3: 20 ticks saturates a 4-bit counter
    interval(20);
    check("t3_value",  32'(meas_value),    32'd15);
    check("t3_ovf",    32'(meas_overflow), 32'd1);
    check("t3_mism",   32'(mismatch),      32'd1);
    check("t3_locked", 32'(locked),        32'd0);
    interval(5);
    check("t3_next_value", 32'(meas_value),    32'd5);
    check("t3_next_ovf",   32'(meas_overflow), 32'd0);
    check("t3_next_mism",  32'(mismatch),      32'd0);

    // 4: consumer stalled across three completions
    cyc(1'b0, 1'b0);
    check("t4_drain_valid", 32'(meas_valid), 32'd0);
    meas_ready = 1'b0;
    interval(4);
    check("t4_a_value", 32'(meas_value), 32'd4);
    check("t4_a_drop",  32'(drop_count), 32'd0);
    check("t4_a_mism",  32'(mismatch),   32'd1);
    interval(5);
    interval(6);
    check("t4_c_value", 32'(meas_value), 32'd6);
    check("t4_c_valid", 32'(meas_valid), 32'd1);
    check("t4_c_drop",  32'(drop_count), 32'd2);
    cyc(1'b0, 1'b0);
    check("t4_hold_value", 32'(meas_value), 32'd6);
    check("t4_hold_valid", 32'(meas_valid), 32'd1);
    meas_ready = 1'b1;
    cyc(1'b0, 1'b0);
    check("t4_accept_valid", 32'(meas_valid), 32'd0);

    // 5: completion coincides with acceptance
    meas_ready = 1'b0;
    interval(5);
    check("t5_pend_value", 32'(meas_value), 32'd5);
    check("t5_pend_drop",  32'(drop_count), 32'd2);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    meas_ready = 1'b1;
    cyc(1'b1, 1'b1);
    check("t5_value", 32'(meas_value), 32'd3);
    check("t5_valid", 32'(meas_valid), 32'd1);
    check("t5_drop",  32'(drop_count), 32'd2);
    check("t5_mism",  32'(mismatch),   32'd1);

    // 6: reset mid-interval with a pending measurement
    meas_ready = 1'b0;
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    rst = 1'b1;
    cyc(1'b1, 1'b0);
    check_all_zero("t6_rst");
    rst = 1'b0;
    cyc(1'b1, 1'b1);
    check("t6_open_valid", 32'(meas_valid), 32'd0);
    check("t6_open_mism",  32'(mismatch),   32'd0);
    interval(5);
    check("t6_first_value", 32'(meas_value), 32'd5);
    check("t6_first_valid", 32'(meas_valid), 32'd1);

    // Held strobe gives a 0-tick interval; expected=0 never matches
    meas_ready = 1'b1;
    expected   = 4'd0;
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    check("b_zero_value", 32'(meas_value), 32'd0);
    check("b_zero_mism",  32'(mismatch),   32'd1);
    check("b_zero_valid", 32'(meas_valid), 32'd1);
    cyc(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
